rw_ram_arbiter: RTL

Two-port round-robin arbiter and access sequencer for the single-port synchronous `rw_seperate_ram` (separate `read`/`write` strobes, 1-cycle registered read).
- Accepts read/write requests from requesters A and B, and serialises them onto the RAM command port.
- Returns read data to the winning requester with a valid pulse.
- Sits between two bus masters and one `rw_seperate_ram` instance.

---
 rtl/rw_ram_arb_pkg.sv | 14 +
 rtl/rr_pick2.sv | 22 ++
 rtl/rw_ram_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rw_ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM state codes and port selectors.
// Later multi-port controllers import the same package.
package rw_ram_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CMD  = 2'd1;
  localparam state_t DATA = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick.
// On a tie the port that was not granted last wins.
module rr_pick2
  import rw_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win_valid,
  output logic       win
);

  always_comb begin
    win_valid = |req;
    win       = PORT_A;
    if (req == 2'b11) begin
      win = ~last;
    end else if (req[1]) begin
      win = PORT_B;
    end
  end

endmodule

// File: rtl/rw_ram_arbiter.sv
// Round-robin arbiter and access sequencer that serialises two requesters
// onto one rw_seperate_ram (separate read/write strobes, 1-cycle registered read).
module rw_ram_arbiter
  import rw_ram_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_datain,
  input  logic [DATA_W-1:0] ram_dataout,
  output logic              busy
);

  state_t            state;
  logic              last;
  logic              cur_port;
  logic              cur_we;
  logic              win_valid;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req      ({b_req, a_req}),
    .last     (last),
    .win_valid(win_valid),
    .win      (win)
  );

  assign sel_we    = (win == PORT_B) ? b_we    : a_we;
  assign sel_addr  = (win == PORT_B) ? b_addr  : a_addr;
  assign sel_wdata = (win == PORT_B) ? b_wdata : a_wdata;

  // CMD lasts two cycles: the first raises the strobe, the second drops it,
  // so the strobe is a clean one-cycle pulse from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= PORT_B;
      cur_port   <= PORT_A;
      cur_we     <= 1'b0;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      ram_addr   <= '0;
      ram_datain <= '0;
      busy       <= 1'b0;
    end else begin
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            cur_port   <= win;
            cur_we     <= sel_we;
            ram_addr   <= sel_addr;
            ram_datain <= sel_wdata;
            last       <= win;
            a_gnt      <= (win == PORT_A);
            b_gnt      <= (win == PORT_B);
            state      <= CMD;
            busy       <= 1'b1;
          end
        end
        CMD: begin
          if (!(ram_read || ram_write)) begin
            ram_read  <= !cur_we;
            ram_write <= cur_we;
          end else if (cur_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          if (cur_port == PORT_B) begin
            b_rdata  <= ram_dataout;
            b_rvalid <= 1'b1;
          end else begin
            a_rdata  <= ram_dataout;
            a_rvalid <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
